// File: rtl/axi_lite_master_ctrl.sv
// AXI4-Lite master: turns a start/address/bytes command into 1..MAX_BEATS single-beat
// write or read transactions. Define AXI_MST_ERR_EN to add slave-error checking and the err port.
module axi_lite_master_ctrl #(
  parameter int MAX_BEATS = 4,
  parameter int ADDR_INC  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       address,
  input  logic              start,
  input  logic [5:0]        bytes,
  input  logic [15:0][31:0] data,
  input  logic              r_w,
  output logic              tr_start,
  output logic              tr_complete,
  output logic [31:0]       r_data,
  output logic              r_valid,
  output logic [31:0]       awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [31:0]       araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
`ifdef AXI_MST_ERR_EN
  output logic              err,
`endif
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state, state_next;
  logic [31:0] base_q;
  logic [4:0]  count_q;
  logic [4:0]  beat;
  logic [4:0]  beat_inc;
  logic [4:0]  count_in;
  logic [31:0] next_addr;
  logic        aw_done, w_done;
  logic        aw_hs, w_hs, aw_fin, w_fin;
  logic        last_beat;
  logic        b_err, r_err;

  // Handshake rule: a transfer happens on a rising edge where valid & ready are both 1.
  // Every valid/ready driven here is a register, so no ready feeds a valid combinationally,
  // and a valid stays high (with its payload frozen) until its own handshake.
  assign aw_hs     = awvalid & awready;
  assign w_hs      = wvalid & wready;
  assign aw_fin    = aw_done | aw_hs;
  assign w_fin     = w_done | w_hs;
  assign last_beat = (beat == count_q - 5'd1);
  assign beat_inc  = beat + 5'd1;
  assign next_addr = base_q + (32'(beat_inc) * 32'(ADDR_INC));
  assign dbg_state = state;

`ifdef AXI_MST_ERR_EN
  assign b_err = bresp[1];
  assign r_err = rresp[1];
`else
  logic unused_resp;
  assign b_err       = 1'b0;
  assign r_err       = 1'b0;
  assign unused_resp = ^{bresp, rresp};
`endif

  always_comb begin
    if (bytes == 6'd0)
      count_in = 5'd1;
    else if (bytes > 6'(MAX_BEATS))
      count_in = 5'(MAX_BEATS);
    else
      count_in = bytes[4:0];
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = r_w ? RADDR : WADDR;
      WADDR: if (aw_fin && w_fin) state_next = WRESP;
      WRESP: if (bvalid) state_next = (last_beat || b_err) ? DONE : WADDR;
      RADDR: if (arready) state_next = RDATA;
      RDATA: if (rvalid) state_next = (last_beat || r_err) ? DONE : RADDR;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q      <= '0;
      count_q     <= '0;
      beat        <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      tr_start    <= 1'b0;
      tr_complete <= 1'b0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      awaddr      <= '0;
      awvalid     <= 1'b0;
      wdata       <= '0;
      wstrb       <= '0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      araddr      <= '0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
`ifdef AXI_MST_ERR_EN
      err         <= 1'b0;
`endif
    end else begin
      tr_start    <= 1'b0;
      tr_complete <= 1'b0;
      r_valid     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= address;
            count_q  <= count_in;
            beat     <= '0;
            tr_start <= 1'b1;
`ifdef AXI_MST_ERR_EN
            err      <= 1'b0;
`endif
            if (r_w) begin
              arvalid <= 1'b1;
              araddr  <= address;
            end else begin
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              awaddr  <= address;
              wdata   <= data[0];
              wstrb   <= 4'hF;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
            end
          end
        end
        WADDR: begin
          if (aw_hs) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (w_hs) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            bready  <= 1'b1;
          end
        end
        WRESP: begin
          if (bvalid) begin
            bready <= 1'b0;
`ifdef AXI_MST_ERR_EN
            if (b_err) err <= 1'b1;
`endif
            // The next beat's write word is sampled here, when that beat begins.
            if (state_next == WADDR) begin
              beat    <= beat_inc;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              awaddr  <= next_addr;
              wdata   <= data[beat_inc[3:0]];
              wstrb   <= 4'hF;
            end else begin
              tr_complete <= 1'b1;
            end
          end
        end
        RADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        end
        RDATA: begin
          if (rvalid) begin
            rready  <= 1'b0;
            r_data  <= rdata;
            r_valid <= 1'b1;
`ifdef AXI_MST_ERR_EN
            if (r_err) err <= 1'b1;
`endif
            if (state_next == RADDR) begin
              beat    <= beat_inc;
              arvalid <= 1'b1;
              araddr  <= next_addr;
            end else begin
              tr_complete <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
